// File: rtl/vga_pkg.sv
// Timing constants and decoder state type for the 640x480 VGA receive path.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned V_SYNC_START = 490;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} dec_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Normalises one sync input to active-high, samples it per pixel strobe and
// flags the strobe on which it first becomes asserted.
module sync_edge_detect #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_strobe,
  input  logic i_sync,
  output logic o_edge_c
);

  logic w_sync;
  logic r_sync;

  assign w_sync = SYNC_ACTIVE_LOW ? ~i_sync : i_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= 1'b0;
    end else if (i_strobe) begin
      r_sync <= w_sync;
    end
  end

  assign o_edge_c = i_strobe & w_sync & ~r_sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive decoder: locks to hsync/vsync, rebuilds col/row and streams active
// pixels as frame-buffer writes. Optional checksum port under VGA_DEC_CHECKSUM_EN.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned H_ACT           = H_ACTIVE,
  parameter int unsigned H_TOT           = H_TOTAL,
  parameter int unsigned H_SYNC          = H_SYNC_START,
  parameter int unsigned V_ACT           = V_ACTIVE,
  parameter int unsigned V_TOT           = V_TOTAL,
  parameter int unsigned V_SYNC          = V_SYNC_START
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              pixel_clk,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              locked,
  output logic [POS_W-1:0]  col,
  output logic [POS_W-1:0]  row,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              sync_err
`ifdef VGA_DEC_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0] checksum
`endif
);

  dec_state_t        r_state;
  dec_state_t        w_state_nxt;
  logic              w_strobe;
  logic              w_h_edge;
  logic              w_v_edge;
  logic              w_col_wrap;
  logic [POS_W-1:0]  w_col_pred;
  logic [POS_W-1:0]  w_row_pred;
  logic [POS_W-1:0]  w_col_nxt;
  logic [POS_W-1:0]  w_row_nxt;
  logic              w_h_miss;
  logic              w_v_miss;
  logic              w_timeout;
  logic              w_lost;
  logic              w_write;
  logic              w_origin;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [POS_W-1:0]  r_hcnt;
  logic [ADDR_W-1:0] r_addr;

  assign w_strobe = enable & pixel_clk;

  sync_edge_detect #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_strobe (w_strobe),
    .i_sync   (hsync),
    .o_edge_c (w_h_edge)
  );

  sync_edge_detect #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_strobe (w_strobe),
    .i_sync   (vsync),
    .o_edge_c (w_v_edge)
  );

  // Free-running position as it would be without any sync reload.
  assign w_col_wrap = (col == POS_W'(H_TOT - 1));
  assign w_col_pred = w_col_wrap ? '0 : col + POS_W'(1);
  assign w_row_pred = !w_col_wrap ? row :
                      (row == POS_W'(V_TOT - 1)) ? '0 : row + POS_W'(1);
  assign w_col_nxt  = w_h_edge ? POS_W'(H_SYNC) : w_col_pred;
  assign w_row_nxt  = w_v_edge ? POS_W'(V_SYNC) : w_row_pred;

  assign w_h_miss  = w_h_edge & (w_col_pred != POS_W'(H_SYNC));
  assign w_v_miss  = w_v_edge & (w_row_pred != POS_W'(V_SYNC));
  assign w_timeout = w_strobe & ~w_h_edge & (r_hcnt == POS_W'(H_TOT));

  always_comb begin
    w_state_nxt = r_state;
    w_lost      = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_v_edge) w_state_nxt = ALIGN;
      end
      ALIGN: begin
        if (w_h_miss || w_v_miss) w_state_nxt = HUNT;
        else if (w_v_edge)        w_state_nxt = LOCKED;
      end
      LOCKED: begin
        if (w_h_miss || w_v_miss || w_timeout) begin
          w_state_nxt = HUNT;
          w_lost      = 1'b1;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= HUNT;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      locked   <= (w_state_nxt == LOCKED);
      sync_err <= w_lost;
    end
  end

  // Position counters and strobes-since-hsync watchdog (saturates at one line).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col    <= '0;
      row    <= '0;
      r_hcnt <= '0;
    end else if (w_strobe) begin
      col <= w_col_nxt;
      row <= w_row_nxt;
      if (w_h_edge)                        r_hcnt <= '0;
      else if (r_hcnt != POS_W'(H_TOT))    r_hcnt <= r_hcnt + POS_W'(1);
    end
  end

  assign w_write  = w_strobe & (r_state == LOCKED) & ~w_lost &
                    (w_col_nxt < POS_W'(H_ACT)) & (w_row_nxt < POS_W'(V_ACT));
  assign w_origin = (w_col_nxt == '0) & (w_row_nxt == '0);
  assign w_last   = (w_col_nxt == POS_W'(H_ACT - 1)) & (w_row_nxt == POS_W'(V_ACT - 1));
  assign w_addr   = w_origin ? '0 : r_addr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      r_addr     <= '0;
    end else begin
      wr_en      <= w_write;
      frame_done <= w_write & w_last;
      if (w_write) begin
        wr_addr <= w_addr;
        wr_data <= pixel_in;
        r_addr  <= w_addr + ADDR_W'(1);
      end
    end
  end

`ifdef VGA_DEC_CHECKSUM_EN
  logic [CSUM_W-1:0] r_acc;
  logic [CSUM_W-1:0] w_acc_nxt;

  assign w_acc_nxt = (w_origin ? '0 : r_acc) + CSUM_W'(pixel_in);

  // Frame sum is published one clk after frame_done, once the last pixel is in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc    <= '0;
      checksum <= '0;
    end else begin
      if (w_write)    r_acc    <= w_acc_nxt;
      if (frame_done) checksum <= r_acc;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster; both sync polarities run in parallel.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HA = 16, HT = 40, HS = 24, HW = 4;
  localparam int VA = 10, VT = 20, VS = 14, VW = 2;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic n_rst, enable, pixel_clk, hsync, vsync;
  logic [7:0] pixel_in;
  logic hsync_b, vsync_b;

  logic a_locked, a_wr_en, a_fd, a_err;
  logic [9:0] a_col, a_row;
  logic [19:0] a_wr_addr;
  logic [7:0] a_wr_data;
  logic b_locked, b_wr_en, b_fd, b_err;
  logic [9:0] b_col, b_row;
  logic [19:0] b_wr_addr;
  logic [7:0] b_wr_data;
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] a_csum, b_csum;
`endif

  assign hsync_b = ~hsync;
  assign vsync_b = ~vsync;

  always #5 clk = ~clk;

  vga_sync_decoder #(.DATA_W(8), .SYNC_ACTIVE_LOW(1'b1), .H_ACT(HA), .H_TOT(HT), .H_SYNC(HS),
                     .V_ACT(VA), .V_TOT(VT), .V_SYNC(VS)) dut_a (
    .clk(clk), .n_rst(n_rst), .enable(enable), .pixel_clk(pixel_clk),
    .hsync(hsync), .vsync(vsync), .pixel_in(pixel_in),
    .locked(a_locked), .col(a_col), .row(a_row), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .frame_done(a_fd), .sync_err(a_err)
`ifdef VGA_DEC_CHECKSUM_EN
    , .checksum(a_csum)
`endif
  );

  vga_sync_decoder #(.DATA_W(8), .SYNC_ACTIVE_LOW(1'b0), .H_ACT(HA), .H_TOT(HT), .H_SYNC(HS),
                     .V_ACT(VA), .V_TOT(VT), .V_SYNC(VS)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable(enable), .pixel_clk(pixel_clk),
    .hsync(hsync_b), .vsync(vsync_b), .pixel_in(pixel_in),
    .locked(b_locked), .col(b_col), .row(b_row), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .frame_done(b_fd), .sync_err(b_err)
`ifdef VGA_DEC_CHECKSUM_EN
    , .checksum(b_csum)
`endif
  );

  int total = 0, bad = 0;

  // Reference model: raster position as a linear pixel index, mode 0/1/2 = hunt/align/locked.
  int m_mode, m_col, m_row, m_since, m_acc;
  bit m_hp, m_vp;
  bit e_locked, e_wr_en, e_fd, e_err;
  int e_col, e_row, e_addr, e_csum;
  logic [7:0] e_data;

  // Observed-trace statistics from dut_a.
  int n_wr, n_err, fd_cnt, first_addr, fd_addr, fd_data, d17;
  int g_col, g_row;

  typedef struct {
    bit en, pc, hs, vs;
    int col, row;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_row = 0; m_since = 0; m_acc = 0; m_hp = 0; m_vp = 0;
    e_locked = 0; e_wr_en = 0; e_fd = 0; e_err = 0;
    e_col = 0; e_row = 0; e_addr = 0; e_csum = 0; e_data = 8'h00;
  endtask

  task automatic model_step(input bit en, input bit pc, input bit hs, input bit vs,
                            input logic [7:0] pix);
    bit h_edge, v_edge, h_miss, v_miss, tmo, lost;
    int pn, pcol, prow;
    if (e_fd) e_csum = m_acc;
    e_wr_en = 0; e_fd = 0; e_err = 0;
    if (en && pc) begin
      h_edge = hs && !m_hp;
      v_edge = vs && !m_vp;
      m_hp = hs; m_vp = vs;
      pn   = (m_row * HT + m_col + 1) % FR;
      pcol = pn % HT;
      prow = pn / HT;
      h_miss = h_edge && (pcol != HS);
      v_miss = v_edge && (prow != VS);
      tmo    = !h_edge && (m_since >= HT);
      m_since = h_edge ? 0 : m_since + 1;
      m_col = h_edge ? HS : pcol;
      m_row = v_edge ? VS : prow;
      lost = (m_mode == 2) && (h_miss || v_miss || tmo);
      if (m_mode == 2 && !lost && m_col < HA && m_row < VA) begin
        e_wr_en = 1;
        e_addr  = m_row * HA + m_col;
        e_data  = pix;
        e_fd    = (m_row == VA - 1) && (m_col == HA - 1);
        m_acc   = ((e_addr == 0 ? 0 : m_acc) + int'(pix)) % 65536;
      end
      case (m_mode)
        0: if (v_edge) m_mode = 1;
        1: if (h_miss || v_miss) m_mode = 0; else if (v_edge) m_mode = 2;
        default: if (lost) m_mode = 0;
      endcase
      e_err = lost;
    end
    e_locked = (m_mode == 2);
    e_col = m_col;
    e_row = m_row;
  endtask

  task automatic check_all();
    logic [63:0] ev, av, bv;
    ev = {12'd0, e_locked, 10'(e_col), 10'(e_row), e_wr_en, 20'(e_addr), e_data, e_fd, e_err};
    av = {12'd0, a_locked, a_col, a_row, a_wr_en, a_wr_addr, a_wr_data, a_fd, a_err};
    bv = {12'd0, b_locked, b_col, b_row, b_wr_en, b_wr_addr, b_wr_data, b_fd, b_err};
    chk("outputs_low_pol", av, ev);
    chk("outputs_high_pol", bv, ev);
`ifdef VGA_DEC_CHECKSUM_EN
    chk("checksum_low_pol", 64'(a_csum), 64'(e_csum));
    chk("checksum_high_pol", 64'(b_csum), 64'(e_csum));
`endif
    if (a_wr_en === 1'b1) begin
      if (n_wr == 0) first_addr = int'(a_wr_addr);
      n_wr++;
      if (a_wr_addr == 20'(HA + 1)) d17 = int'(a_wr_data);
    end
    if (a_fd === 1'b1) begin
      fd_cnt++; fd_addr = int'(a_wr_addr); fd_data = int'(a_wr_data);
    end
    if (a_err === 1'b1) n_err++;
  endtask

  task automatic clear_stats();
    n_wr = 0; n_err = 0; fd_cnt = 0; first_addr = -1; fd_addr = -1; fd_data = -1; d17 = -1;
  endtask

  // One clk: drive (logical sync levels), advance model, then compare after the edge.
  task automatic tick(input bit rstn, input bit en, input bit pc, input bit hs, input bit vs,
                      input logic [7:0] pix);
    n_rst = rstn; enable = en; pixel_clk = pc;
    hsync = ~hs; vsync = ~vs; pixel_in = pix;
    if (!rstn) model_reset();
    else model_step(en, pc, hs, vs, pix);
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic bit g_hs();
    return (g_col >= HS) && (g_col < HS + HW);
  endfunction

  function automatic bit g_vs();
    return (g_row >= VS) && (g_row < VS + VW);
  endfunction

  task automatic gen_steps(input int n, input bit hmask);
    int done;
    bit pc;
    done = 0;
    while (done < n) begin
      pc = ($urandom_range(0, 3) != 0);
      tick(1'b1, 1'b1, pc, g_hs() && !hmask, g_vs(), 8'((g_col + g_row) & 255));
      if (pc) begin
        done++;
        g_col++;
        if (g_col == HT) begin
          g_col = 0;
          g_row = (g_row + 1) % VT;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 2, 0};
    tbl[4]  = '{1, 1, 1, 0, HS, 0};
    tbl[5]  = '{1, 1, 1, 0, HS + 1, 0};
    tbl[6]  = '{1, 1, 1, 1, HS + 2, VS};
    tbl[7]  = '{1, 1, 0, 0, HS + 3, VS};
    tbl[8]  = '{1, 0, 1, 0, HS + 3, VS};
    tbl[9]  = '{1, 1, 1, 0, HS, VS};
    tbl[10] = '{1, 1, 0, 1, HS + 1, VS};

    clear_stats();
    model_reset();
    do_reset(3);
    chk("reset_state", {12'd0, a_locked, a_col, a_row, a_wr_en, a_wr_addr, a_wr_data, a_fd, a_err}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      tick(1'b1, tbl[i].en, tbl[i].pc, tbl[i].hs, tbl[i].vs, 8'(i));
      chk($sformatf("tbl%0d_col", i), 64'(a_col), 64'(tbl[i].col));
      chk($sformatf("tbl%0d_row", i), 64'(a_row), 64'(tbl[i].row));
      chk($sformatf("tbl%0d_locked", i), 64'(a_locked), 64'd0);
    end

    // Clean frames from a timing generator: lock on the second vsync, full writes in frame 3.
    do_reset(2);
    g_col = 0; g_row = 0;
    clear_stats();
    gen_steps(VS * HT + 1, 1'b0);
    chk("locked_after_vs1", 64'(a_locked), 64'd0);
    gen_steps(FR, 1'b0);
    chk("locked_after_vs2", 64'(a_locked), 64'd1);
    gen_steps(FR - VS * HT - 1, 1'b0);
    chk("no_writes_before_lock", 64'(n_wr), 64'd0);
    clear_stats();
    gen_steps(FR, 1'b0);
    chk("frame3_writes", 64'(n_wr), 64'(HA * VA));
    chk("frame3_first_addr", 64'(first_addr), 64'd0);
    chk("frame3_last_addr", 64'(fd_addr), 64'(HA * VA - 1));
    chk("frame3_last_data", 64'(fd_data), 64'((VA - 1 + HA - 1) & 255));
    chk("frame3_done_count", 64'(fd_cnt), 64'd1);
    chk("data_at_row1_col1", 64'(d17), 64'd2);

    // Enable held low for 37 clks mid-line: no error, address sequence intact.
    clear_stats();
    gen_steps(3 * HT + 5, 1'b0);
    for (int i = 0; i < 37; i++)
      tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), g_hs(), g_vs(), 8'($urandom));
    gen_steps(FR - (3 * HT + 5), 1'b0);
    chk("pause_writes", 64'(n_wr), 64'(HA * VA));
    chk("pause_no_err", 64'(n_err), 64'd0);
    chk("pause_last_addr", 64'(fd_addr), 64'(HA * VA - 1));
    chk("pause_locked", 64'(a_locked), 64'd1);

    // One 41-strobe line: error at the next hsync, writes resume two vsyncs later.
    clear_stats();
    gen_steps(2 * HT + 30, 1'b0);
    tick(1'b1, 1'b1, 1'b1, g_hs(), g_vs(), 8'((g_col + g_row) & 255));
    gen_steps(HT, 1'b0);
    chk("long_line_err", 64'(n_err), 64'd1);
    chk("long_line_unlocked", 64'(a_locked), 64'd0);
    n_wr = 0;
    gen_steps(FR - (2 * HT + 30) - HT, 1'b0);
    gen_steps(FR, 1'b0);
    chk("relock_no_writes", 64'(n_wr), 64'd0);
    chk("relocked", 64'(a_locked), 64'd1);
    clear_stats();
    gen_steps(FR, 1'b0);
    chk("relock_writes", 64'(n_wr), 64'(HA * VA));

    // Missing hsync while locked: watchdog drops lock.
    clear_stats();
    gen_steps(HT + 8, 1'b1);
    chk("timeout_err", 64'(n_err), 64'd1);
    chk("timeout_unlocked", 64'(a_locked), 64'd0);

    // Reset mid-frame, then relock needs two vsync edges.
    gen_steps(50, 1'b0);
    do_reset(2);
    chk("mid_reset", {12'd0, a_locked, a_col, a_row, a_wr_en, a_wr_addr, a_wr_data, a_fd, a_err}, 64'd0);
    gen_steps(FR, 1'b0);
    chk("post_reset_one_vs", 64'(a_locked), 64'd0);
    gen_steps(FR, 1'b0);
    chk("post_reset_two_vs", 64'(a_locked), 64'd1);
    gen_steps(FR / 2, 1'b0);

    // Random pins against the model.
    begin
      bit hs, vs;
      hs = 0; vs = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) hs = !hs;
        if ($urandom_range(0, 29) == 0) vs = !vs;
        tick(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 1)), hs, vs, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
